// File: rtl/issue_ctrl_pkg.sv
// Shared types and constants for the issue controller and its scoreboard.
// Register-index helpers keep x0 handling in one place.
package issue_ctrl_pkg;

  localparam int NUM_REGS = 32;
  localparam int REG_AW   = $clog2(NUM_REGS);
  localparam int LOAD_CW  = 3;

  typedef enum logic [1:0] {
    READY    = 2'd0,
    WAIT_GNT = 2'd1,
    WAIT_PC  = 2'd2
  } issue_state_e;

  // One-hot register mask; x0 never produces a bit, so it can never become pending.
  function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [REG_AW-1:0] addr,
                                                     input logic              en);
    logic [NUM_REGS-1:0] mask;
    mask = '0;
    if (en && (addr != '0)) begin
      mask[addr] = 1'b1;
    end
    return mask;
  endfunction

endpackage

// File: rtl/issue_scoreboard.sv
// Pending-write scoreboard: set/clear take effect at the next edge, set wins a same-register tie.
// Lookups read only the registered vector; no backpressure.
module issue_scoreboard
  import issue_ctrl_pkg::*;
(
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                set_en,
  input  logic [REG_AW-1:0]   set_addr,
  input  logic                clr_en,
  input  logic [REG_AW-1:0]   clr_addr,
  input  logic [REG_AW-1:0]   rs1_addr,
  input  logic [REG_AW-1:0]   rs2_addr,
  input  logic [REG_AW-1:0]   rd_addr,
  output logic                rs1_hit,
  output logic                rs2_hit,
  output logic                rd_hit,
  output logic [NUM_REGS-1:0] pending
);

  logic [NUM_REGS-1:0] pending_q;
  logic [NUM_REGS-1:0] set_mask;
  logic [NUM_REGS-1:0] clr_mask;

  assign set_mask = reg_onehot(set_addr, set_en);
  assign clr_mask = reg_onehot(clr_addr, clr_en);

  // Clear first, then OR in the set so an issue overlapping a writeback keeps the bit.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pending_q <= '0;
    end else begin
      pending_q <= (pending_q & ~clr_mask) | set_mask;
    end
  end

  assign rs1_hit = (rs1_addr != '0) & pending_q[rs1_addr];
  assign rs2_hit = (rs2_addr != '0) & pending_q[rs2_addr];
  assign rd_hit  = (rd_addr  != '0) & pending_q[rd_addr];
  assign pending = pending_q;

endmodule

// File: rtl/issue_ctrl.sv
// In-order issue controller: RAW/WAW scoreboard stall, LSU grant and PC-ALU waits, load credit limit.
// Zero-latency issue (issue_en = valid & ready); ready drops on hazard, full load count or a non-READY state.
module issue_ctrl
  import issue_ctrl_pkg::*;
#(
  parameter int MAX_LOADS = 2
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                instr_valid_i,
  output logic                instr_ready_o,
  input  logic [REG_AW-1:0]   rs1_addr_i,
  input  logic [REG_AW-1:0]   rs2_addr_i,
  input  logic [REG_AW-1:0]   rd_addr_i,
  input  logic                rs1_used_i,
  input  logic                rs2_used_i,
  input  logic                rd_we_i,
  input  logic                is_load_i,
  input  logic                is_store_i,
  input  logic                is_pc_i,
  output logic                issue_en_o,
  input  logic                lsu_gnt_i,
  input  logic                lsu_rvalid_i,
  input  logic                wb_valid_i,
  input  logic [REG_AW-1:0]   wb_addr_i,
  input  logic                pc_done_i,
  input  logic                pc_taken_i,
  output logic                kill_o,
  output logic [NUM_REGS-1:0] pending_o,
  output logic [LOAD_CW-1:0]  loads_o,
  output logic [1:0]          state_o
);

  issue_state_e       state_q;
  issue_state_e       state_d;
  logic [LOAD_CW-1:0] loads_q;
  logic               rs1_hit;
  logic               rs2_hit;
  logic               rd_hit;
  logic               hazard;
  logic               load_full;
  logic               load_inc;
  logic               load_dec;

  issue_scoreboard u_scoreboard (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .set_en   (issue_en_o & rd_we_i),
    .set_addr (rd_addr_i),
    .clr_en   (wb_valid_i),
    .clr_addr (wb_addr_i),
    .rs1_addr (rs1_addr_i),
    .rs2_addr (rs2_addr_i),
    .rd_addr  (rd_addr_i),
    .rs1_hit  (rs1_hit),
    .rs2_hit  (rs2_hit),
    .rd_hit   (rd_hit),
    .pending  (pending_o)
  );

  assign hazard        = (rs1_used_i & rs1_hit) | (rs2_used_i & rs2_hit) | (rd_we_i & rd_hit);
  assign load_full     = is_load_i & (loads_q == LOAD_CW'(MAX_LOADS));
  assign instr_ready_o = (state_q == READY) & ~hazard & ~load_full;
  assign issue_en_o    = instr_valid_i & instr_ready_o;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= READY;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    kill_o  = 1'b0;
    unique case (state_q)
      READY: begin
        if (issue_en_o) begin
          if (is_load_i | is_store_i) begin
            state_d = WAIT_GNT;
          end else if (is_pc_i) begin
            state_d = WAIT_PC;
          end
        end
      end
      WAIT_GNT: begin
        if (lsu_gnt_i) begin
          state_d = READY;
        end
      end
      WAIT_PC: begin
        if (pc_done_i) begin
          state_d = READY;
          kill_o  = pc_taken_i;
        end
      end
      default: begin
        state_d = READY;
      end
    endcase
  end

  // A return with nothing outstanding is stray and must not wrap the count.
  assign load_inc = issue_en_o & is_load_i;
  assign load_dec = lsu_rvalid_i & (loads_q != '0);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      loads_q <= '0;
    end else begin
      unique case ({load_inc, load_dec})
        2'b10:   loads_q <= loads_q + LOAD_CW'(1);
        2'b01:   loads_q <= loads_q - LOAD_CW'(1);
        default: loads_q <= loads_q;
      endcase
    end
  end

  assign loads_o = loads_q;
  assign state_o = state_q;

endmodule

// File: tb/tb_issue_ctrl.sv
// Self-checking bench for issue_ctrl: directed scenarios plus randomized traffic against a reference model.
module tb_issue_ctrl;

  localparam int MAX_LOADS = 2;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        instr_valid_i;
  logic        instr_ready_o;
  logic [4:0]  rs1_addr_i, rs2_addr_i, rd_addr_i;
  logic        rs1_used_i, rs2_used_i, rd_we_i;
  logic        is_load_i, is_store_i, is_pc_i;
  logic        issue_en_o;
  logic        lsu_gnt_i, lsu_rvalid_i;
  logic        wb_valid_i;
  logic [4:0]  wb_addr_i;
  logic        pc_done_i, pc_taken_i;
  logic        kill_o;
  logic [31:0] pending_o;
  logic [2:0]  loads_o;
  logic [1:0]  state_o;

  int checks   = 0;
  int failures = 0;

  // Reference model: set of pending registers, outstanding load count, and what the unit waits for.
  bit [31:0] m_pend;
  int        m_loads;
  int        m_wait;   // 0 nothing, 1 LSU grant, 2 PC-ALU result

  issue_ctrl #(.MAX_LOADS(MAX_LOADS)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .instr_valid_i(instr_valid_i), .instr_ready_o(instr_ready_o),
    .rs1_addr_i(rs1_addr_i), .rs2_addr_i(rs2_addr_i), .rd_addr_i(rd_addr_i),
    .rs1_used_i(rs1_used_i), .rs2_used_i(rs2_used_i), .rd_we_i(rd_we_i),
    .is_load_i(is_load_i), .is_store_i(is_store_i), .is_pc_i(is_pc_i),
    .issue_en_o(issue_en_o),
    .lsu_gnt_i(lsu_gnt_i), .lsu_rvalid_i(lsu_rvalid_i),
    .wb_valid_i(wb_valid_i), .wb_addr_i(wb_addr_i),
    .pc_done_i(pc_done_i), .pc_taken_i(pc_taken_i), .kill_o(kill_o),
    .pending_o(pending_o), .loads_o(loads_o), .state_o(state_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic bit m_ready();
    bit haz;
    haz = (rs1_used_i && rs1_addr_i != 0 && m_pend[rs1_addr_i]) ||
          (rs2_used_i && rs2_addr_i != 0 && m_pend[rs2_addr_i]) ||
          (rd_we_i    && rd_addr_i  != 0 && m_pend[rd_addr_i]);
    return (m_wait == 0) && !haz && !(is_load_i && m_loads == MAX_LOADS);
  endfunction

  task automatic model_tick();
    bit iss;
    iss = instr_valid_i && m_ready();
    if (wb_valid_i) m_pend[wb_addr_i] = 1'b0;
    if (iss && rd_we_i && rd_addr_i != 0) m_pend[rd_addr_i] = 1'b1;
    if (iss && is_load_i && !(lsu_rvalid_i && m_loads > 0)) m_loads++;
    else if (!(iss && is_load_i) && lsu_rvalid_i && m_loads > 0) m_loads--;
    if (m_wait == 0 && iss && (is_load_i || is_store_i)) m_wait = 1;
    else if (m_wait == 0 && iss && is_pc_i) m_wait = 2;
    else if (m_wait == 1 && lsu_gnt_i) m_wait = 0;
    else if (m_wait == 2 && pc_done_i) m_wait = 0;
  endtask

  // Inputs change only at the falling edge; the model advances with the DUT at the rising edge.
  task automatic tick();
    @(posedge clk_i);
    if (rst_i) begin
      m_pend = '0; m_loads = 0; m_wait = 0;
    end else begin
      model_tick();
    end
    @(negedge clk_i);
  endtask

  task automatic idle();
    instr_valid_i = 0; rs1_addr_i = 0; rs2_addr_i = 0; rd_addr_i = 0;
    rs1_used_i = 0; rs2_used_i = 0; rd_we_i = 0;
    is_load_i = 0; is_store_i = 0; is_pc_i = 0;
    lsu_gnt_i = 0; lsu_rvalid_i = 0; wb_valid_i = 0; wb_addr_i = 0;
    pc_done_i = 0; pc_taken_i = 0;
  endtask

  task automatic set_instr(input bit [4:0] rs1, input bit u1, input bit [4:0] rs2, input bit u2,
                           input bit [4:0] rd, input bit we, input bit ld, input bit st, input bit pc);
    instr_valid_i = 1; rs1_addr_i = rs1; rs1_used_i = u1; rs2_addr_i = rs2; rs2_used_i = u2;
    rd_addr_i = rd; rd_we_i = we; is_load_i = ld; is_store_i = st; is_pc_i = pc;
  endtask

  task automatic do_reset();
    rst_i = 1; idle();
    tick();
    rst_i = 0;
  endtask

  task automatic test_reset();
    rst_i = 1; idle();
    #1;
    checks++; if (state_o !== 2'd0) begin failures++; $display("FAIL reset_state: got %0d expected 0", state_o); end
    checks++; if (pending_o !== 32'h0) begin failures++; $display("FAIL reset_pending: got %h expected 0", pending_o); end
    checks++; if (loads_o !== 3'd0) begin failures++; $display("FAIL reset_loads: got %0d expected 0", loads_o); end
    checks++; if (kill_o !== 1'b0) begin failures++; $display("FAIL reset_kill: got %b expected 0", kill_o); end
    @(negedge clk_i);
    do_reset();
  endtask

  task automatic test_raw_hazard();
    do_reset();
    set_instr(1, 1, 2, 1, 5, 1, 0, 0, 0);   // ADD x5,x1,x2
    #1;
    checks++; if (issue_en_o !== 1'b1) begin failures++; $display("FAIL raw_first_issue: got %b expected 1", issue_en_o); end
    tick();
    set_instr(5, 1, 0, 0, 6, 1, 0, 0, 0);   // ADD x6,x5
    #1;
    checks++; if (instr_ready_o !== 1'b0) begin failures++; $display("FAIL raw_stall: got %b expected 0", instr_ready_o); end
    checks++; if (pending_o !== 32'h20) begin failures++; $display("FAIL raw_pending: got %h expected 00000020", pending_o); end
    tick();
    wb_valid_i = 1; wb_addr_i = 5;
    #1;
    checks++; if (instr_ready_o !== 1'b0) begin failures++; $display("FAIL raw_wb_same_cycle: got %b expected 0", instr_ready_o); end
    tick();
    wb_valid_i = 0;
    #1;
    checks++; if (issue_en_o !== 1'b1) begin failures++; $display("FAIL raw_issue_after_wb: got %b expected 1", issue_en_o); end
    tick();
    idle();
    #1;
    checks++; if (pending_o !== 32'h40) begin failures++; $display("FAIL raw_pending_after: got %h expected 00000040", pending_o); end
  endtask

  task automatic test_load();
    do_reset();
    set_instr(2, 1, 0, 0, 7, 1, 1, 0, 0);   // LW x7
    #1;
    checks++; if (issue_en_o !== 1'b1) begin failures++; $display("FAIL load_issue: got %b expected 1", issue_en_o); end
    tick();
    for (int i = 0; i < 3; i++) begin
      set_instr(0, 0, 0, 0, 1, 1, 0, 0, 0); // independent ADD x1 must still be held
      #1;
      checks++; if (state_o !== 2'd1) begin failures++; $display("FAIL load_wait_state[%0d]: got %0d expected 1", i, state_o); end
      checks++; if (instr_ready_o !== 1'b0) begin failures++; $display("FAIL load_wait_ready[%0d]: got %b expected 0", i, instr_ready_o); end
      tick();
    end
    idle(); lsu_gnt_i = 1;
    tick();
    lsu_gnt_i = 0;
    #1;
    checks++; if (state_o !== 2'd0) begin failures++; $display("FAIL load_after_gnt_state: got %0d expected 0", state_o); end
    checks++; if (loads_o !== 3'd1) begin failures++; $display("FAIL load_count_before_rvalid: got %0d expected 1", loads_o); end
    tick(); tick();
    checks++; if (loads_o !== 3'd1) begin failures++; $display("FAIL load_count_held: got %0d expected 1", loads_o); end
    lsu_rvalid_i = 1;
    tick();
    lsu_rvalid_i = 0;
    #1;
    checks++; if (loads_o !== 3'd0) begin failures++; $display("FAIL load_count_after_rvalid: got %0d expected 0", loads_o); end
  endtask

  task automatic test_max_loads();
    do_reset();
    for (int i = 0; i < 2; i++) begin
      set_instr(0, 0, 0, 0, 5'(8 + i), 1, 1, 0, 0);
      tick();
      idle(); lsu_gnt_i = 1;
      tick();
    end
    idle();
    set_instr(0, 0, 0, 0, 10, 1, 1, 0, 0);  // third load
    #1;
    checks++; if (loads_o !== 3'd2) begin failures++; $display("FAIL max_loads_count: got %0d expected 2", loads_o); end
    checks++; if (instr_ready_o !== 1'b0) begin failures++; $display("FAIL max_loads_held: got %b expected 0", instr_ready_o); end
    lsu_rvalid_i = 1;
    #1;
    checks++; if (issue_en_o !== 1'b0) begin failures++; $display("FAIL max_loads_rvalid_same_cycle: got %b expected 0", issue_en_o); end
    tick();
    #1;
    checks++; if (issue_en_o !== 1'b1) begin failures++; $display("FAIL max_loads_issue_with_rvalid: got %b expected 1", issue_en_o); end
    tick();
    lsu_rvalid_i = 0; instr_valid_i = 0;
    #1;
    checks++; if (loads_o !== 3'd1) begin failures++; $display("FAIL max_loads_inc_dec: got %0d expected 1", loads_o); end
    checks++; if (state_o !== 2'd1) begin failures++; $display("FAIL max_loads_state: got %0d expected 1", state_o); end
  endtask

  task automatic test_branch();
    do_reset();
    lsu_gnt_i = 1; pc_done_i = 1; pc_taken_i = 1;  // stray completions in READY
    #1;
    checks++; if (kill_o !== 1'b0) begin failures++; $display("FAIL branch_stray_kill: got %b expected 0", kill_o); end
    tick();
    idle();
    set_instr(1, 1, 2, 1, 0, 0, 0, 0, 1);   // BEQ x1,x2
    #1;
    checks++; if (issue_en_o !== 1'b1) begin failures++; $display("FAIL branch_issue: got %b expected 1", issue_en_o); end
    tick();
    idle();
    #1;
    checks++; if (state_o !== 2'd2) begin failures++; $display("FAIL branch_wait_state: got %0d expected 2", state_o); end
    checks++; if (kill_o !== 1'b0) begin failures++; $display("FAIL branch_no_early_kill: got %b expected 0", kill_o); end
    pc_done_i = 1; pc_taken_i = 1;
    #1;
    checks++; if (kill_o !== 1'b1) begin failures++; $display("FAIL branch_taken_kill: got %b expected 1", kill_o); end
    tick();
    idle();
    #1;
    checks++; if (kill_o !== 1'b0) begin failures++; $display("FAIL branch_kill_single: got %b expected 0", kill_o); end
    checks++; if (state_o !== 2'd0) begin failures++; $display("FAIL branch_ready_after: got %0d expected 0", state_o); end
    set_instr(1, 1, 2, 1, 0, 0, 0, 0, 1);
    tick();
    idle(); pc_done_i = 1; pc_taken_i = 0;
    #1;
    checks++; if (kill_o !== 1'b0) begin failures++; $display("FAIL branch_not_taken_kill: got %b expected 0", kill_o); end
    tick();
    idle();
    #1;
    checks++; if (state_o !== 2'd0) begin failures++; $display("FAIL branch_not_taken_state: got %0d expected 0", state_o); end
  endtask

  task automatic test_x0_and_set_wins();
    do_reset();
    set_instr(1, 1, 0, 0, 0, 1, 0, 0, 0);   // write to x0
    tick();
    idle();
    #1;
    checks++; if (pending_o !== 32'h0) begin failures++; $display("FAIL x0_pending: got %h expected 0", pending_o); end
    set_instr(1, 1, 0, 0, 3, 1, 0, 0, 0);
    wb_valid_i = 1; wb_addr_i = 3;
    tick();
    idle();
    #1;
    checks++; if (pending_o !== 32'h8) begin failures++; $display("FAIL set_wins_pending: got %h expected 00000008", pending_o); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    set_instr(0, 0, 0, 0, 7, 1, 1, 0, 0);
    tick();
    idle();
    #1;
    checks++; if (pending_o !== 32'h80) begin failures++; $display("FAIL rstmid_pre_pending: got %h expected 00000080", pending_o); end
    #1;
    rst_i = 1;
    #1;
    checks++; if (state_o !== 2'd0) begin failures++; $display("FAIL rstmid_state: got %0d expected 0", state_o); end
    checks++; if (pending_o !== 32'h0) begin failures++; $display("FAIL rstmid_pending: got %h expected 0", pending_o); end
    checks++; if (loads_o !== 3'd0) begin failures++; $display("FAIL rstmid_loads: got %0d expected 0", loads_o); end
    tick();
    rst_i = 0;
    set_instr(0, 0, 0, 0, 4, 1, 0, 0, 0);
    #1;
    checks++; if (issue_en_o !== 1'b1) begin failures++; $display("FAIL rstmid_issue_after: got %b expected 1", issue_en_o); end
    tick();
    idle();
  endtask

  task automatic test_random();
    bit exp_ready, exp_issue, exp_kill;
    int cls;
    do_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      idle();
      instr_valid_i = ($urandom_range(0, 3) != 0);
      rs1_addr_i = 5'($urandom_range(0, 7)); rs1_used_i = 1'($urandom_range(0, 1));
      rs2_addr_i = 5'($urandom_range(0, 7)); rs2_used_i = 1'($urandom_range(0, 1));
      rd_addr_i  = 5'($urandom_range(0, 7)); rd_we_i    = 1'($urandom_range(0, 1));
      cls = $urandom_range(0, 5);
      is_load_i = (cls == 0); is_store_i = (cls == 1); is_pc_i = (cls == 2);
      lsu_gnt_i    = ($urandom_range(0, 2) == 0);
      lsu_rvalid_i = ($urandom_range(0, 3) == 0);
      wb_valid_i   = ($urandom_range(0, 2) == 0);
      wb_addr_i    = 5'($urandom_range(0, 7));
      pc_done_i    = ($urandom_range(0, 2) == 0);
      pc_taken_i   = 1'($urandom_range(0, 1));
      #1;
      exp_ready = m_ready();
      exp_issue = instr_valid_i && exp_ready;
      exp_kill  = (m_wait == 2) && pc_done_i && pc_taken_i;
      checks++; if (instr_ready_o !== exp_ready) begin failures++; $display("FAIL rnd_ready@%0d: got %b expected %b", cyc, instr_ready_o, exp_ready); end
      checks++; if (issue_en_o !== exp_issue) begin failures++; $display("FAIL rnd_issue@%0d: got %b expected %b", cyc, issue_en_o, exp_issue); end
      checks++; if (kill_o !== exp_kill) begin failures++; $display("FAIL rnd_kill@%0d: got %b expected %b", cyc, kill_o, exp_kill); end
      checks++; if (pending_o !== m_pend) begin failures++; $display("FAIL rnd_pending@%0d: got %h expected %h", cyc, pending_o, m_pend); end
      checks++; if (loads_o !== 3'(m_loads)) begin failures++; $display("FAIL rnd_loads@%0d: got %0d expected %0d", cyc, loads_o, m_loads); end
      checks++; if (state_o !== 2'(m_wait)) begin failures++; $display("FAIL rnd_state@%0d: got %0d expected %0d", cyc, state_o, m_wait); end
      tick();
    end
    idle();
  endtask

  initial begin
    m_pend = '0; m_loads = 0; m_wait = 0;
    rst_i = 1; idle();
    test_reset();
    test_raw_hazard();
    test_load();
    test_max_loads();
    test_branch();
    test_x0_and_set_wins();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
